// File: rtl/count_event_pkg.sv
// Shared constants for the count event logger: record kinds and record width helper.
package count_event_pkg;

   localparam logic [1:0] EV_NONE  = 2'b00;
   localparam logic [1:0] EV_MATCH = 2'b01;
   localparam logic [1:0] EV_WRAP  = 2'b10;
   localparam logic [1:0] EV_BOTH  = 2'b11;

   // A record is {kind[1:0], count[size-1:0]}.
   function automatic int rec_width(input int size);
      return size + 2;
   endfunction

endpackage

// File: rtl/count_event_fifo.sv
// Synchronous FIFO with wrapping pointers; occupancy is wr-rd with one extra MSB.
// A push while full is accepted only when a pop frees the slot on the same edge.
module count_event_fifo #(
   parameter int W     = 7,
   parameter int Depth = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(Depth):0]   level
);

   localparam int AW = $clog2(Depth);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem [Depth];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign level   = wr_ptr - rd_ptr;
   assign full    = (level == LW'(Depth));
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + LW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + LW'(1);
      end
   end

   // Storage needs no reset: empty gating hides stale entries.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/count_event_logger.sv
// Samples the count bus, detects WRAP / MATCH events and queues {kind,count} records.
// Optional COUNT_EVENT_DROP_CNT_EN adds a saturating drop_cnt[7:0] output.
module count_event_logger
   import count_event_pkg::*;
#(
   parameter int Size  = 5,
   parameter int Depth = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [Size-1:0]          count,
   input  logic [Size-1:0]          threshold,
   input  logic                     ev_ready,
   input  logic                     ovf_clear,
   output logic                     ev_valid,
   output logic [1:0]               ev_kind,
   output logic [Size-1:0]          ev_count,
   output logic                     overflow,
   output logic [$clog2(Depth):0]   level
`ifdef COUNT_EVENT_DROP_CNT_EN
   ,
   output logic [7:0]               drop_cnt
`endif
);

   localparam int RW = rec_width(Size);

   logic [Size-1:0] prev_count;
   logic            armed;
   logic            wrap;
   logic            match;
   logic            event_hit;
   logic [1:0]      kind;
   logic            pop;
   logic            drop;
   logic            full;
   logic            empty;
   logic [RW-1:0]   rdata;

   assign wrap      = armed && (count < prev_count);
   assign match     = armed && (count == threshold) && (prev_count != threshold);
   assign event_hit = wrap || match;

   always_comb begin
      kind = EV_NONE;
      if (wrap && match) kind = EV_BOTH;
      else if (wrap)     kind = EV_WRAP;
      else if (match)    kind = EV_MATCH;
   end

   // Handshake: the head record transfers on any edge where ev_valid && ev_ready;
   // ev_valid never depends on ev_ready, and ev_ready while empty is ignored.
   assign ev_valid = !empty;
   assign pop      = ev_valid && ev_ready;
   assign drop     = event_hit && full && !pop;
   assign ev_kind  = empty ? EV_NONE : rdata[RW-1 -: 2];
   assign ev_count = empty ? '0 : rdata[Size-1:0];

   count_event_fifo #(
      .W     (RW),
      .Depth (Depth)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (event_hit),
      .pop   (pop),
      .wdata ({kind, count}),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // The first sample after reset only seeds prev_count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_count <= '0;
         armed      <= 1'b0;
      end else begin
         prev_count <= count;
         armed      <= 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)          overflow <= 1'b0;
      else if (drop)      overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
   end

`ifdef COUNT_EVENT_DROP_CNT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         drop_cnt <= 8'd0;
      else if (ovf_clear)
         drop_cnt <= drop ? 8'd1 : 8'd0;
      else if (drop && (drop_cnt != 8'hFF))
         drop_cnt <= drop_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_count_event_logger.sv
// Self-checking bench for count_event_logger (Size=5, Depth=4); directed scenarios plus
// randomized traffic against a queue-based reference model. Honors COUNT_EVENT_DROP_CNT_EN.
module tb_count_event_logger;

   localparam int SIZE  = 5;
   localparam int DEPTH = 4;

   logic       clock;
   logic       reset;
   logic [4:0] count;
   logic [4:0] threshold;
   logic       ev_ready;
   logic       ovf_clear;
   logic       ev_valid;
   logic [1:0] ev_kind;
   logic [4:0] ev_count;
   logic       overflow;
   logic [2:0] level;
`ifdef COUNT_EVENT_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [6:0] exp_q[$];
   logic [4:0] m_prev;
   bit         m_armed;
   bit         m_ovf;
   int         m_drops;

   count_event_logger #(.Size(SIZE), .Depth(DEPTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .count     (count),
      .threshold (threshold),
      .ev_ready  (ev_ready),
      .ovf_clear (ovf_clear),
      .ev_valid  (ev_valid),
      .ev_kind   (ev_kind),
      .ev_count  (ev_count),
      .overflow  (overflow),
      .level     (level)
`ifdef COUNT_EVENT_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic model_reset();
      exp_q.delete();
      m_prev  = '0;
      m_armed = 0;
      m_ovf   = 0;
      m_drops = 0;
   endtask

   // Drive one cycle and advance the model; returns 1 ns after the edge.
   task automatic step(input logic [4:0] c, input logic [4:0] t, input logic r, input logic clr);
      bit pop, wrap, match, drop;
      int sz;
      count = c; threshold = t; ev_ready = r; ovf_clear = clr;
      @(posedge clock);
      sz    = exp_q.size();
      pop   = (sz > 0) && r;
      wrap  = m_armed && (c < m_prev);
      match = m_armed && (c == t) && (m_prev != t);
      drop  = 0;
      if (pop) void'(exp_q.pop_front());
      if (wrap || match) begin
         if (sz < DEPTH || pop) exp_q.push_back({wrap, match, c});
         else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (clr) m_drops = drop ? 1 : 0;
      else if (drop && m_drops < 255) m_drops++;
      m_prev  = c;
      m_armed = 1;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; count = '0; ev_ready = 1'b0; ovf_clear = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      threshold = 5'd3; count = 5'd7; ev_ready = 1'b0; ovf_clear = 1'b0;
      reset = 1'b1;
      #2;
      n_checks++; if (ev_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", ev_valid); end
      n_checks++; if (ev_kind !== 2'b00) begin n_errors++; $display("FAIL reset_kind got %b exp 00", ev_kind); end
      n_checks++; if (ev_count !== 5'd0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", ev_count); end
      n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
      n_checks++; if (level !== 3'd0) begin n_errors++; $display("FAIL reset_level got %0d exp 0", level); end
      do_reset();
   endtask

   task automatic test_sequence();
      logic [6:0] seen[$];
      do_reset();
      for (int i = 0; i < 32; i++) begin
         step(5'(i), 5'd3, 1'b1, 1'b0);
         if (ev_valid) seen.push_back({ev_kind, ev_count});
      end
      for (int i = 0; i < 2; i++) begin
         step(5'd0, 5'd3, 1'b1, 1'b0);
         if (ev_valid) seen.push_back({ev_kind, ev_count});
      end
      n_checks++; if (seen.size() !== 2) begin n_errors++; $display("FAIL seq_nrec got %0d exp 2", seen.size()); end
      if (seen.size() >= 2) begin
         n_checks++; if (seen[0] !== 7'b01_00011) begin n_errors++; $display("FAIL seq_rec0 got %b exp 0100011", seen[0]); end
         n_checks++; if (seen[1] !== 7'b10_00000) begin n_errors++; $display("FAIL seq_rec1 got %b exp 1000000", seen[1]); end
      end
   endtask

   task automatic test_both();
      do_reset();
      step(5'd30, 5'd0, 1'b0, 1'b0);
      step(5'd31, 5'd0, 1'b0, 1'b0);
      step(5'd0,  5'd0, 1'b0, 1'b0);
      step(5'd0,  5'd0, 1'b0, 1'b0);
      n_checks++; if (level !== 3'd1) begin n_errors++; $display("FAIL both_level got %0d exp 1", level); end
      n_checks++; if ({ev_valid, ev_kind, ev_count} !== 8'b1_11_00000) begin
         n_errors++; $display("FAIL both_rec got %b exp 11100000", {ev_valid, ev_kind, ev_count}); end
   endtask

   task automatic test_overflow();
      logic [6:0] drain_exp [4] = '{7'b01_00011, 7'b10_00000, 7'b01_00011, 7'b10_00000};
      do_reset();
      step(5'd0, 5'd3, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step((i % 2 == 0) ? 5'd3 : 5'd0, 5'd3, 1'b0, 1'b0);
      n_checks++; if (level !== 3'd4) begin n_errors++; $display("FAIL ovf_level got %0d exp 4", level); end
      n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if ({ev_valid, ev_kind, ev_count} !== {1'b1, drain_exp[i]}) begin
            n_errors++; $display("FAIL ovf_drain%0d got %b exp %b", i, {ev_valid, ev_kind, ev_count}, {1'b1, drain_exp[i]}); end
         step(5'd3, 5'd3, 1'b1, 1'b0);
      end
      n_checks++; if ({ev_valid, level} !== 4'b0_000) begin n_errors++; $display("FAIL ovf_empty got %b exp 0000", {ev_valid, level}); end
      n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
      step(5'd3, 5'd3, 1'b0, 1'b1);
      n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      step(5'd0, 5'd3, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step((i % 2 == 0) ? 5'd3 : 5'd0, 5'd3, 1'b0, 1'b0);
      n_checks++; if (level !== 3'd4) begin n_errors++; $display("FAIL b2b_fill got %0d exp 4", level); end
      step(5'd3, 5'd3, 1'b1, 1'b0);
      n_checks++; if (level !== 3'd4) begin n_errors++; $display("FAIL b2b_level got %0d exp 4", level); end
      n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL b2b_ovf got %b exp 0", overflow); end
      n_checks++; if ({ev_kind, ev_count} !== 7'b10_00000) begin n_errors++; $display("FAIL b2b_head got %b exp 1000000", {ev_kind, ev_count}); end
   endtask

   task automatic test_hold_and_reset();
      int n_rec = 0;
      do_reset();
      step(5'd0, 5'd3, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(5'd3, 5'd3, 1'b1, 1'b0);
         if (ev_valid) n_rec++;
      end
      step(5'd4, 5'd3, 1'b1, 1'b0);
      if (ev_valid) n_rec++;
      n_checks++; if (n_rec !== 1) begin n_errors++; $display("FAIL hold_nmatch got %0d exp 1", n_rec); end
      step(5'd0, 5'd3, 1'b0, 1'b0);
      step(5'd3, 5'd3, 1'b0, 1'b0);
      n_checks++; if (level !== 3'd2) begin n_errors++; $display("FAIL hold_queued got %0d exp 2", level); end
      reset = 1'b1;
      #2;
      n_checks++; if ({ev_valid, level} !== 4'b0_000) begin n_errors++; $display("FAIL async_reset got %b exp 0000", {ev_valid, level}); end
      @(posedge clock); #1;
      reset = 1'b0;
      model_reset();
      step(5'd3, 5'd3, 1'b0, 1'b0);
      n_checks++; if ({ev_valid, level} !== 4'b0_000) begin n_errors++; $display("FAIL unarmed got %b exp 0000", {ev_valid, level}); end
   endtask

   task automatic test_random();
      logic [4:0] thr = 5'd3;
      logic [4:0] c   = 5'd0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) thr = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 0) c = c + 5'd1;
         else c = 5'($urandom_range(0, 31));
         step(c, thr, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
         n_checks++;
         if (exp_q.size() > 0) begin
            if ({ev_valid, ev_kind, ev_count} !== {1'b1, exp_q[0]}) begin
               n_errors++; $display("FAIL rnd_head cyc %0d got %b exp %b", i, {ev_valid, ev_kind, ev_count}, {1'b1, exp_q[0]}); end
         end else if ({ev_valid, ev_kind, ev_count} !== 8'd0) begin
            n_errors++; $display("FAIL rnd_empty cyc %0d got %b exp 0", i, {ev_valid, ev_kind, ev_count});
         end
         n_checks++; if (level !== 3'(exp_q.size())) begin n_errors++; $display("FAIL rnd_level cyc %0d got %0d exp %0d", i, level, exp_q.size()); end
         n_checks++; if (overflow !== m_ovf) begin n_errors++; $display("FAIL rnd_ovf cyc %0d got %b exp %b", i, overflow, m_ovf); end
`ifdef COUNT_EVENT_DROP_CNT_EN
         n_checks++; if (drop_cnt !== 8'(m_drops)) begin n_errors++; $display("FAIL rnd_drops cyc %0d got %0d exp %0d", i, drop_cnt, m_drops); end
`endif
      end
   endtask

`ifdef COUNT_EVENT_DROP_CNT_EN
   task automatic test_drop_cnt();
      do_reset();
      step(5'd0, 5'd3, 1'b0, 1'b0);
      for (int i = 0; i < 304; i++) step((i % 2 == 0) ? 5'd3 : 5'd0, 5'd3, 1'b0, 1'b0);
      n_checks++; if (drop_cnt !== 8'd255) begin n_errors++; $display("FAIL drop_sat got %0d exp 255", drop_cnt); end
      n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL drop_ovf got %b exp 1", overflow); end
      step(5'd0, 5'd3, 1'b0, 1'b1);
      n_checks++; if ({overflow, drop_cnt} !== 9'd0) begin n_errors++; $display("FAIL drop_clear got %b exp 0", {overflow, drop_cnt}); end
      step(5'd3, 5'd3, 1'b0, 1'b1);
      n_checks++; if ({overflow, drop_cnt} !== {1'b1, 8'd1}) begin n_errors++; $display("FAIL drop_clr_race got %b exp 100000001", {overflow, drop_cnt}); end
   endtask
`endif

   initial begin
      reset = 1'b0; count = '0; threshold = 5'd3; ev_ready = 1'b0; ovf_clear = 1'b0;
      model_reset();
      test_reset();
      test_sequence();
      test_both();
      test_overflow();
      test_back_to_back();
      test_hold_and_reset();
      test_random();
`ifdef COUNT_EVENT_DROP_CNT_EN
      test_drop_cnt();
`endif
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
